// File: rtl/frac_lut4_cfg_writer.sv
// frac_lut4_cfg_writer: shifts LUT init words MSB-first into a config scan chain,
// returns displaced old words and strobes a latch after the last word.
module frac_lut4_cfg_writer #(
    parameter int NUM_LUTS = 4,
    parameter int LUT_W    = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic             wr_valid,
    input  logic [LUT_W-1:0] wr_data,
    output logic             wr_ready,
    output logic             cfg_dout,
    output logic             cfg_shift,
    input  logic             cfg_din,
    output logic             cfg_latch,
    output logic             rd_valid,
    output logic [LUT_W-1:0] rd_data,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(LUT_W + 1);
    localparam int WW = $clog2(NUM_LUTS + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;
    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [WW-1:0]    word_cnt;
    logic [LUT_W-1:0] shreg;
    logic [LUT_W-1:0] shreg_nxt;
    assign cfg_dout  = shreg[LUT_W-1];
    assign shreg_nxt = {shreg[LUT_W-2:0], cfg_din};
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shreg     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b1;
            cfg_shift <= 1'b0;
            cfg_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_valid  <= 1'b0;
            cfg_latch <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (wr_valid && wr_ready) begin
                    shreg     <= wr_data;
                    bit_cnt   <= '0;
                    state     <= SHIFT;
                    wr_ready  <= 1'b0;
                    cfg_shift <= 1'b1;
                    busy      <= 1'b1;
                end
                SHIFT: begin
                    shreg   <= shreg_nxt;
                    bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(LUT_W - 1)) begin
                        // displaced word is complete once the final tail bit arrives
                        rd_data   <= shreg_nxt;
                        rd_valid  <= 1'b1;
                        cfg_shift <= 1'b0;
                        if (word_cnt == WW'(NUM_LUTS - 1)) begin
                            word_cnt  <= '0;
                            state     <= LATCH;
                            cfg_latch <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + WW'(1);
                            state    <= IDLE;
                            wr_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
                LATCH: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    wr_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    wr_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
